// File: rtl/rfa_wb_sched.sv
// Writeback-port scheduler: buffers LSU destination writes in a FIFO and arbitrates them
// against SALU writes, with a starvation guard that forces one LSU write through.
module rfa_wb_sched #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lsu_req_valid,
    input  logic [DATA_W-1:0]          lsu_req_data,
    output logic                       lsu_req_ready,
    input  logic                       salu_req,
    output logic                       salu_stall,
    output logic                       rfa_salu_req,
    output logic                       rfa_lsu_wr_req,
    output logic [DATA_W-1:0]          rfa_lsu_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [CntW-1:0]   starve_q, starve_d;

    logic nonempty;
    logic full;
    logic force_lsu;
    logic push;
    logic pop;

    assign nonempty  = (occ_q != '0);
    assign full      = (occ_q == OccW'(DEPTH));
    assign force_lsu = (starve_q == CntW'(STARVE_MAX)) && nonempty;

    // Ready depends only on registered occupancy, so a full FIFO never accepts even when popping.
    assign lsu_req_ready = ~full;
    assign push          = lsu_req_valid & ~full;
    assign pop           = rfa_lsu_wr_req;

    assign occupancy    = occ_q;
    assign rfa_lsu_data = mem_q[rd_ptr_q];

    always_comb begin
        rfa_salu_req   = 1'b0;
        rfa_lsu_wr_req = 1'b0;
        salu_stall     = 1'b0;
        if (force_lsu) begin
            rfa_lsu_wr_req = 1'b1;
            salu_stall     = salu_req;
        end else if (salu_req) begin
            rfa_salu_req = 1'b1;
        end else if (nonempty) begin
            rfa_lsu_wr_req = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Counts cycles where a buffered LSU write lost to the SALU; any pop restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (pop || !nonempty) begin
            starve_d = '0;
        end else if (salu_req && !force_lsu && (starve_q != CntW'(STARVE_MAX))) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= lsu_req_data;
        end
    end

endmodule
